pe_traffic_gen: RTL and testbench
=================================

PE_TRAFFIC_GEN -- requirements
Module: pe_traffic_gen

Interface
REQ-001 SHALL have parameter ADDRESS, default 0: this PE's node address.
REQ-002 SHALL have parameter ADDR_W, default 4: destination address width.
REQ-003 SHALL have parameter NUM_PE, default 16: node count, 2 to 2^ADDR_W.
REQ-004 SHALL have parameter DATA_W, default 32: payload/timestamp width.
REQ-005 SHALL have parameter PKT_LIMIT, default 20: flits to inject, 1 to 2^32-1.
REQ-006 SHALL have parameter PATTERN, default 2: 0 RANDOM, 1 COMPLEMENT, 2 REVERSE, 3 ROTATION, 4 TRANSPOSE, 5 TORNADO, 6 NEIGHBOUR.
REQ-007 SHALL have parameter INJ_GAP, default 0: idle cycles between accepted flit and next offer.
REQ-008 SHALL have ports clk in 1 (single clock); rst in 1, asynchronous, active-low.
REQ-009 SHALL have start in 1: level, injection enable, sampled in IDLE.
REQ-010 SHALL have i_data in FLIT_W, i_data_valid in 1, o_data_ready out 1: receive channel.
REQ-011 SHALL have o_data out FLIT_W, o_data_valid out 1, i_data_ready in 1: transmit channel.
REQ-012 SHALL have tx_count out 32, rx_count out 32, lat_max out DATA_W, lat_sum out 48, done out 1.

Function
REQ-013 FLIT_W SHALL be 3+ADDR_W+DATA_W; o_data = {1'b1 valid, 1'b1 tail, dest, 1'b0 vc, timestamp}.
REQ-014 A DATA_W-bit free-running cycle counter SHALL increment every clk and wrap modulo 2^DATA_W.
REQ-015 FSM states IDLE, OFFER, GAP, DONE; IDLE->OFFER when start=1.
REQ-016 On IDLE->OFFER and GAP->OFFER, o_data SHALL capture counter and dest; o_data stable while o_data_valid=1.
REQ-017 o_data_valid SHALL be 1 only in OFFER, held until i_data_ready=1 at a clk edge (accept), independent of ready.
REQ-018 On accept tx_count SHALL increment; next state DONE if tx_count reaches PKT_LIMIT, else GAP (INJ_GAP>0) or OFFER (INJ_GAP=0, back-to-back, new flit next cycle).
REQ-019 GAP SHALL last exactly INJ_GAP cycles.
REQ-020 start deassertion SHALL pause only between flits: an offered flit stays until accepted; then FSM returns to IDLE keeping tx_count.
REQ-021 DONE SHALL be terminal until reset; done=1 in DONE.
REQ-022 dest SHALL be: COMPLEMENT ~ADDRESS; REVERSE bit-reversed; ROTATION dest[j]=ADDRESS[(j+1)%ADDR_W]; TRANSPOSE dest[j]=ADDRESS[(j+ADDR_W/2)%ADDR_W]; TORNADO (ADDRESS+(NUM_PE+1)/2)%NUM_PE; NEIGHBOUR (ADDRESS+1)%NUM_PE.
REQ-023 RANDOM SHALL use a 16-bit Fibonacci LFSR (taps 16,14,13,11) seeded ADDRESS+1, dest = lfsr % NUM_PE, advancing once per accept.
REQ-024 o_data_ready SHALL be constant 1; each cycle with i_data_valid=1 SHALL increment rx_count (wraps at 2^32).
REQ-025 Latency SHALL be (counter - i_data[DATA_W-1:0]) mod 2^DATA_W, valid across counter wrap.
REQ-026 Simultaneous transmit accept and receive in one cycle SHALL both be counted.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, o_data_valid=0, o_data=0, all counters/statistics 0, done=0, LFSR=seed, including mid-offer.

Configuration
REQ-028 With PE_LATENCY_STATS_EN defined, lat_sum SHALL accumulate latency (saturating at 2^48-1) and lat_max track maximum; undefined, both SHALL be tied 0 with no accumulator logic.

Structure
REQ-029 Pattern encodings, FSM state enum and FLIT_W function SHALL be in shared package noc_tg_pkg.
REQ-030 The destination generator (pattern mux plus LFSR) SHALL be sub-module pe_dest_gen.

Verification
REQ-031 ADDRESS=3, ADDR_W=4, PATTERN=2, ready=1 -> dest 4'b1100 on every flit, 20 flits on 20 consecutive cycles, then done=1, tx_count=20.
REQ-032 INJ_GAP=3, ready=1 -> flits accepted every 4 cycles; timestamps differ by 4.
REQ-033 Hold i_data_ready=0 for 10 cycles mid-offer -> o_data_valid stays 1, o_data unchanged, tx_count unchanged.
REQ-034 Drive i_data_valid with stamp 0xFFFF_FFFE when counter=0x0000_0003 -> latency 5, lat_max=5 (macro on), 0 (macro off).
REQ-035 Assert rst=0 mid-offer asynchronously -> o_data_valid=0 before next edge, counters 0, restart from IDLE.
REQ-036 PATTERN=0, two PEs with ADDRESS 0 and 1 -> differing dest sequences, all < NUM_PE, repeatable after reset.

Source files
------------

// File: rtl/noc_tg_pkg.sv
// Shared definitions for the NoC traffic generator: traffic pattern
// encodings, generator FSM states, flit width helper and the LFSR step.
package noc_tg_pkg;

    localparam int PAT_RANDOM     = 0;
    localparam int PAT_COMPLEMENT = 1;
    localparam int PAT_REVERSE    = 2;
    localparam int PAT_ROTATION   = 3;
    localparam int PAT_TRANSPOSE  = 4;
    localparam int PAT_TORNADO    = 5;
    localparam int PAT_NEIGHBOUR  = 6;

    localparam int LFSR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_GAP,
        ST_DONE
    } tg_state_e;

    // Flit layout: {valid, tail, dest, vc, timestamp}
    function automatic int flit_w(input int addr_w, input int data_w);
        return 3 + addr_w + data_w;
    endfunction

    // 16-bit Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [LFSR_W-1:0] lfsr16_next(input logic [LFSR_W-1:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/pe_dest_gen.sv
// Destination generator: fixed permutation patterns resolve to a constant;
// RANDOM uses an LFSR that advances once per accepted flit. dest_nxt is the
// destination that applies after the pending advance, so a back-to-back flit
// captured on the accept edge already sees the new value.
module pe_dest_gen
    import noc_tg_pkg::*;
#(
    parameter int ADDRESS = 0,
    parameter int ADDR_W  = 4,
    parameter int NUM_PE  = 16,
    parameter int PATTERN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [ADDR_W-1:0] dest,
    output logic [ADDR_W-1:0] dest_nxt
);

    function automatic logic [ADDR_W-1:0] fixed_dest();
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] d;
        a = ADDR_W'(ADDRESS);
        d = '0;
        case (PATTERN)
            PAT_COMPLEMENT: d = ~a;
            PAT_REVERSE:
                for (int unsigned j = 0; j < ADDR_W; j++) d[j] = a[ADDR_W-1-j];
            PAT_ROTATION:
                for (int unsigned j = 0; j < ADDR_W; j++) d[j] = a[(j+1) % ADDR_W];
            PAT_TRANSPOSE:
                for (int unsigned j = 0; j < ADDR_W; j++) d[j] = a[(j+ADDR_W/2) % ADDR_W];
            PAT_TORNADO:   d = ADDR_W'((ADDRESS + (NUM_PE + 1) / 2) % NUM_PE);
            PAT_NEIGHBOUR: d = ADDR_W'((ADDRESS + 1) % NUM_PE);
            default:       d = '0;
        endcase
        return d;
    endfunction

    generate
        if (PATTERN == PAT_RANDOM) begin : g_random
            logic [LFSR_W-1:0] lfsr;
            logic [LFSR_W-1:0] lfsr_adv;

            assign lfsr_adv = lfsr16_next(lfsr);

            // LFSR state, reseeded on reset, stepped once per accept
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    lfsr <= LFSR_W'(ADDRESS + 1);
                else if (advance)
                    lfsr <= lfsr_adv;
            end

            assign dest     = ADDR_W'(32'(lfsr) % 32'(NUM_PE));
            assign dest_nxt = ADDR_W'(32'(lfsr_adv) % 32'(NUM_PE));
        end else begin : g_fixed
            localparam logic [ADDR_W-1:0] FIXED_DEST = fixed_dest();
            logic fixed_unused;

            assign dest         = FIXED_DEST;
            assign dest_nxt     = FIXED_DEST;
            assign fixed_unused = clk ^ rst ^ advance;
        end
    endgenerate

endmodule

// File: rtl/pe_traffic_gen.sv
// Processing-element traffic generator: injects PKT_LIMIT single-flit
// packets towards a pattern-selected destination, counts received flits
// and (with PE_LATENCY_STATS_EN defined) accumulates receive latency.
module pe_traffic_gen
    import noc_tg_pkg::*;
#(
    parameter int          ADDRESS   = 0,
    parameter int          ADDR_W    = 4,
    parameter int          NUM_PE    = 16,
    parameter int          DATA_W    = 32,
    parameter int unsigned PKT_LIMIT = 20,
    parameter int          PATTERN   = 2,
    parameter int          INJ_GAP   = 0,
    localparam int         FLIT_W    = flit_w(ADDR_W, DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FLIT_W-1:0] i_data,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    output logic [FLIT_W-1:0] o_data,
    output logic              o_data_valid,
    input  logic              i_data_ready,
    output logic [31:0]       tx_count,
    output logic [31:0]       rx_count,
    output logic [DATA_W-1:0] lat_max,
    output logic [47:0]       lat_sum,
    output logic              done
);

    localparam logic [31:0] GAP_LOAD = (INJ_GAP > 0) ? 32'(INJ_GAP - 1) : '0;
    localparam logic [31:0] LAST_TX  = 32'(PKT_LIMIT - 1);

    tg_state_e         state;
    tg_state_e         state_nxt;
    logic [DATA_W-1:0] cyc_cnt;
    logic [31:0]       gap_cnt;
    logic              accept;
    logic              load_flit;
    logic              adv_capture;
    logic              load_gap;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] dest_nxt;

    assign accept       = (state == ST_OFFER) && i_data_ready;
    assign o_data_valid = (state == ST_OFFER);
    assign done         = (state == ST_DONE);
    assign o_data_ready = 1'b1;

    pe_dest_gen #(
        .ADDRESS (ADDRESS),
        .ADDR_W  (ADDR_W),
        .NUM_PE  (NUM_PE),
        .PATTERN (PATTERN)
    ) u_dest_gen (
        .clk      (clk),
        .rst      (rst),
        .advance  (accept),
        .dest     (dest),
        .dest_nxt (dest_nxt)
    );

    // Free-running timestamp counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cyc_cnt <= '0;
        else
            cyc_cnt <= cyc_cnt + 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state; start only gates the boundary between flits
    always_comb begin
        state_nxt   = state;
        load_flit   = 1'b0;
        adv_capture = 1'b0;
        load_gap    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_OFFER;
                    load_flit = 1'b1;
                end
            end
            ST_OFFER: begin
                if (accept) begin
                    if (tx_count == LAST_TX) begin
                        state_nxt = ST_DONE;
                    end else if (!start) begin
                        state_nxt = ST_IDLE;
                    end else if (INJ_GAP == 0) begin
                        state_nxt   = ST_OFFER;
                        load_flit   = 1'b1;
                        adv_capture = 1'b1;
                    end else begin
                        state_nxt = ST_GAP;
                        load_gap  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    if (start) begin
                        state_nxt = ST_OFFER;
                        load_flit = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DONE: state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outgoing flit register, gap timer and transmit count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_data   <= '0;
            gap_cnt  <= '0;
            tx_count <= '0;
        end else begin
            if (load_flit)
                o_data <= {1'b1, 1'b1, (adv_capture ? dest_nxt : dest), 1'b0, cyc_cnt};
            if (load_gap)
                gap_cnt <= GAP_LOAD;
            else if ((state == ST_GAP) && (gap_cnt != '0))
                gap_cnt <= gap_cnt - 1'b1;
            if (accept)
                tx_count <= tx_count + 1'b1;
        end
    end

    // Receive flit count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rx_count <= '0;
        else if (i_data_valid)
            rx_count <= rx_count + 1'b1;
    end

`ifdef PE_LATENCY_STATS_EN
    logic [DATA_W-1:0] latency;
    logic [48:0]       sum_ext;
    logic              rx_hdr_unused;

    assign latency       = cyc_cnt - i_data[DATA_W-1:0];
    assign sum_ext       = {1'b0, lat_sum} + 49'(latency);
    assign rx_hdr_unused = ^i_data[FLIT_W-1:DATA_W];

    // Latency statistics: saturating sum and running maximum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_sum <= '0;
            lat_max <= '0;
        end else if (i_data_valid) begin
            lat_sum <= sum_ext[48] ? '1 : sum_ext[47:0];
            if (latency > lat_max)
                lat_max <= latency;
        end
    end
`else
    logic rx_data_unused;

    assign lat_sum        = '0;
    assign lat_max        = '0;
    assign rx_data_unused = ^i_data;
`endif

endmodule

// File: tb/tb_pe_traffic_gen.sv
// Scoreboard bench for pe_traffic_gen: expected flits are queued as
// stimulus is applied and popped when a flit is accepted.
module tb_pe_traffic_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0, start_r = 1'b0;
    logic        ready_a = 1'b0, ready_b = 1'b0, ready_r = 1'b0;
    logic        rx_v = 1'b0;
    logic [38:0] rx_d = '0;

    logic [38:0] a_data, b_data, r0_data, r1_data;
    logic        a_valid, b_valid, r0_valid, r1_valid;
    logic        a_ordy, b_ordy, r0_ordy, r1_ordy;
    logic [31:0] a_tx, b_tx, r0_tx, r1_tx;
    logic [31:0] a_rx, b_rx, r0_rx, r1_rx;
    logic [31:0] a_lmax, b_lmax, r0_lmax, r1_lmax;
    logic [47:0] a_lsum, b_lsum, r0_lsum, r1_lsum;
    logic        a_done, b_done, r0_done, r1_done;

    logic [38:0] qa[$], qb[$], qr0[$], qr1[$];
    logic [31:0] cyc;
    int unsigned exp_rx;
    logic [31:0] exp_lmax;
    logic [47:0] exp_lsum;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    pe_traffic_gen #(.ADDRESS(3), .ADDR_W(4), .NUM_PE(16), .DATA_W(32),
                     .PKT_LIMIT(20), .PATTERN(2), .INJ_GAP(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .i_data(rx_d), .i_data_valid(rx_v),
        .o_data_ready(a_ordy), .o_data(a_data), .o_data_valid(a_valid),
        .i_data_ready(ready_a), .tx_count(a_tx), .rx_count(a_rx),
        .lat_max(a_lmax), .lat_sum(a_lsum), .done(a_done));

    pe_traffic_gen #(.ADDRESS(5), .ADDR_W(4), .NUM_PE(16), .DATA_W(32),
                     .PKT_LIMIT(4), .PATTERN(5), .INJ_GAP(3)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .i_data('0), .i_data_valid(1'b0),
        .o_data_ready(b_ordy), .o_data(b_data), .o_data_valid(b_valid),
        .i_data_ready(ready_b), .tx_count(b_tx), .rx_count(b_rx),
        .lat_max(b_lmax), .lat_sum(b_lsum), .done(b_done));

    pe_traffic_gen #(.ADDRESS(0), .ADDR_W(4), .NUM_PE(10), .DATA_W(32),
                     .PKT_LIMIT(8), .PATTERN(0), .INJ_GAP(0)) u_r0 (
        .clk(clk), .rst(rst), .start(start_r), .i_data('0), .i_data_valid(1'b0),
        .o_data_ready(r0_ordy), .o_data(r0_data), .o_data_valid(r0_valid),
        .i_data_ready(ready_r), .tx_count(r0_tx), .rx_count(r0_rx),
        .lat_max(r0_lmax), .lat_sum(r0_lsum), .done(r0_done));

    pe_traffic_gen #(.ADDRESS(1), .ADDR_W(4), .NUM_PE(10), .DATA_W(32),
                     .PKT_LIMIT(8), .PATTERN(0), .INJ_GAP(0)) u_r1 (
        .clk(clk), .rst(rst), .start(start_r), .i_data('0), .i_data_valid(1'b0),
        .o_data_ready(r1_ordy), .o_data(r1_data), .o_data_valid(r1_valid),
        .i_data_ready(ready_r), .tx_count(r1_tx), .rx_count(r1_rx),
        .lat_max(r1_lmax), .lat_sum(r1_lsum), .done(r1_done));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        logic fb;
        fb = l[15] ^ l[13] ^ l[12] ^ l[10];
        return {l[14:0], fb};
    endfunction

    task automatic push_a(input logic [31:0] ts);
        qa.push_back({2'b11, 4'b1100, 1'b0, ts});
    endtask

    // Observe outputs mid-cycle, then advance to the next negedge.
    task automatic step();
        logic [31:0] lat;
        if (a_valid && ready_a) begin
            if (qa.size() == 0) check("a_flit_unexpected", a_valid, 1'b0);
            else                check("a_flit", a_data, qa.pop_front());
        end
        if (b_valid && ready_b) begin
            if (qb.size() == 0) check("b_flit_unexpected", b_valid, 1'b0);
            else                check("b_flit", b_data, qb.pop_front());
        end
        if (r0_valid && ready_r) begin
            check("r0_dest_range", r0_data[36:33] < 4'd10, 1'b1);
            if (qr0.size() == 0) check("r0_flit_unexpected", r0_valid, 1'b0);
            else                 check("r0_flit", r0_data, qr0.pop_front());
        end
        if (r1_valid && ready_r) begin
            check("r1_dest_range", r1_data[36:33] < 4'd10, 1'b1);
            if (qr1.size() == 0) check("r1_flit_unexpected", r1_valid, 1'b0);
            else                 check("r1_flit", r1_data, qr1.pop_front());
        end
        if (rx_v) begin
            exp_rx++;
            lat = cyc - rx_d[31:0];
`ifdef PE_LATENCY_STATS_EN
            if (lat > exp_lmax) exp_lmax = lat;
            exp_lsum = exp_lsum + 48'(lat);
`endif
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_model();
        qa.delete(); qb.delete(); qr0.delete(); qr1.delete();
        exp_rx   = 0;
        exp_lmax = '0;
        exp_lsum = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        cyc = '0;
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_rx"}, a_rx, 64'(exp_rx));
        check({tag, "_lat_max"}, a_lmax, exp_lmax);
        check({tag, "_lat_sum"}, a_lsum, exp_lsum);
    endtask

    task automatic push_random(input logic [31:0] c);
        logic [15:0] l0, l1;
        l0 = 16'd1;
        l1 = 16'd2;
        for (int k = 0; k < 8; k++) begin
            qr0.push_back({2'b11, 4'(l0 % 16'd10), 1'b0, c + 32'(k)});
            qr1.push_back({2'b11, 4'(l1 % 16'd10), 1'b0, c + 32'(k)});
            l0 = lfsr_adv(l0);
            l1 = lfsr_adv(l1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] c;
        logic [38:0] w5;

        do_reset();
        check("rst_valid", a_valid, 1'b0);
        check("rst_data", a_data, '0);
        check("rst_tx", a_tx, '0);
        check("rst_rx", a_rx, '0);
        check("rst_done", a_done, 1'b0);
        check("rst_lat_max", a_lmax, '0);
        check("rst_lat_sum", a_lsum, '0);
        check("rst_b_valid", b_valid, 1'b0);
        check("o_data_ready", a_ordy, 1'b1);

        // Receive across timestamp wrap: counter 3, stamp 0xFFFF_FFFE
        repeat (3) step();
        rx_v = 1'b1;
        rx_d = {7'b0, 32'hFFFF_FFFE};
        step();
        rx_v = 1'b0;
        step();
        check_rx("wrap");

        // Back-to-back REVERSE injection with concurrent receive traffic
        c = cyc;
        for (int k = 0; k < 20; k++) push_a(c + 32'(k));
        start_a = 1'b1;
        ready_a = 1'b1;
        rx_v    = 1'b1;
        rx_d    = {7'b0, 32'h10};
        repeat (21) step();
        rx_v = 1'b0;
        check("b2b_done", a_done, 1'b1);
        check("b2b_tx", a_tx, 32'd20);
        check("b2b_valid", a_valid, 1'b0);
        check("b2b_queue_left", qa.size(), 0);
        check_rx("b2b");
        repeat (3) step();
        check("done_terminal", a_done, 1'b1);
        check("done_tx_hold", a_tx, 32'd20);

        // TORNADO with INJ_GAP=3: capture every 4 cycles
        c = cyc;
        for (int k = 0; k < 4; k++) qb.push_back({2'b11, 4'd13, 1'b0, c + 32'(4 * k)});
        start_b = 1'b1;
        ready_b = 1'b1;
        repeat (15) step();
        check("gap_done", b_done, 1'b1);
        check("gap_tx", b_tx, 32'd4);
        check("gap_queue_left", qb.size(), 0);

        // RANDOM on two PEs, then the same sequence after reset
        for (int pass = 0; pass < 2; pass++) begin
            c = cyc;
            push_random(c);
            start_r = 1'b1;
            ready_r = 1'b1;
            repeat (9) step();
            check("rnd_r0_done", r0_done, 1'b1);
            check("rnd_r1_done", r1_done, 1'b1);
            check("rnd_r0_queue_left", qr0.size(), 0);
            check("rnd_r1_queue_left", qr1.size(), 0);
            start_r = 1'b0;
            start_a = 1'b0;
            start_b = 1'b0;
            do_reset();
        end

        // Stall mid-offer, then pause between flits with start low
        c = cyc;
        for (int k = 0; k < 6; k++) push_a(c + 32'(k));
        w5 = {2'b11, 4'b1100, 1'b0, c + 32'd5};
        start_a = 1'b1;
        ready_a = 1'b1;
        repeat (6) step();
        ready_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", a_valid, 1'b1);
            check("stall_data", a_data, w5);
            check("stall_tx", a_tx, 32'd5);
            step();
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            check("pause_valid", a_valid, 1'b0);
            check("pause_tx", a_tx, 32'd6);
            step();
        end
        start_a = 1'b1;
        c = cyc;
        for (int k = 6; k < 20; k++) push_a(c + 32'(k - 6));
        repeat (15) step();
        check("resume_done", a_done, 1'b1);
        check("resume_tx", a_tx, 32'd20);
        check("resume_queue_left", qa.size(), 0);

        // Asynchronous reset while a flit is on offer
        start_a = 1'b0;
        do_reset();
        c = cyc;
        push_a(c);
        push_a(c + 32'd1);
        start_a = 1'b1;
        ready_a = 1'b1;
        rx_v    = 1'b1;
        rx_d    = {7'b0, 32'h5};
        step();
        step();
        ready_a = 1'b0;
        step();
        check("pre_rst_valid", a_valid, 1'b1);
        check("pre_rst_tx", a_tx, 32'd1);
        check("pre_rst_rx", a_rx, 64'(exp_rx));
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", a_valid, 1'b0);
        check("async_rst_data", a_data, '0);
        check("async_rst_tx", a_tx, '0);
        check("async_rst_rx", a_rx, '0);
        check("async_rst_done", a_done, 1'b0);
        check("async_rst_lat_sum", a_lsum, '0);
        rx_v = 1'b0;
        clear_model();
        @(negedge clk);
        #1 rst = 1'b1;
        cyc = '0;
        check("post_rst_idle", a_valid, 1'b0);
        ready_a = 1'b1;
        push_a(32'd0);
        step();
        step();
        check("restart_tx", a_tx, 32'd1);
        check("restart_queue_left", qa.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
